// File: rtl/ring_osc_freq_meter_if.sv
// rtl/ring_osc_freq_meter_if.sv - control/result bundle between lab top-level and ring_osc_freq_meter
// Ports (signals):
//   start     measurement request (driven by master)
//   busy      1 while the meter is settling or measuring
//   done      one-cycle pulse; count/overflow valid from this cycle
//   count     rising edges seen in the last completed gate window
//   overflow  1 if the last window's edge counter saturated
// Modports: master = lab controls, slave = meter.
interface ring_osc_freq_meter_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output start,
    input  busy,
    input  done,
    input  count,
    input  overflow
  );

  modport slave (
    input  start,
    output busy,
    output done,
    output count,
    output overflow
  );
endinterface

// File: rtl/ring_osc_freq_meter.sv
// rtl/ring_osc_freq_meter.sv - sequencer and rising-edge frequency counter for a ring oscillator
// Purpose: on start, release the oscillator from reset, wait SETTLE_CYCLES,
//   count synchronized oscillator rising edges for GATE_CYCLES, report the
//   result with a one-cycle done pulse and park the oscillator in reset.
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   osc_in   oscillator output, asynchronous to clk
//   osc_rst  oscillator reset, 1 = held (registered)
//   bus      slave side of ring_osc_freq_meter_if (start/busy/done/count/overflow)
module ring_osc_freq_meter #(
  parameter int SETTLE_CYCLES = 16,
  parameter int GATE_CYCLES   = 1024,
  parameter int CNT_W         = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  osc_in,
  output logic                  osc_rst,
  ring_osc_freq_meter_if.slave  bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  // One shared down-counter serves both windows; it only ever holds N-1.
  localparam int TMAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  logic [1:0]             state;
  logic [TW-1:0]          timer;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_last;
  logic                   prev;
  logic                   osc_edge;
  logic [CNT_W-1:0]       edge_cnt;
  logic                   ovf;
  logic [CNT_W-1:0]       cnt_next;
  logic                   ovf_next;

  assign sync_last = sync[SYNC_STAGES-1];
  assign osc_edge  = sync_last & ~prev;

  // Saturating increment; an edge arriving while already at all-ones is lost
  // and marks the window as overflowed.
  always_comb begin
    cnt_next = edge_cnt;
    ovf_next = ovf;
    if (osc_edge) begin
      if (&edge_cnt) begin
        ovf_next = 1'b1;
      end else begin
        cnt_next = edge_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      sync         <= '0;
      prev         <= 1'b0;
      edge_cnt     <= '0;
      ovf          <= 1'b0;
      osc_rst      <= 1'b1;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.count    <= '0;
      bus.overflow <= 1'b0;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], osc_in};
      prev     <= sync_last;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= SETTLE;
            timer    <= TW'(SETTLE_CYCLES - 1);
            osc_rst  <= 1'b0;
            bus.busy <= 1'b1;
          end
        end
        SETTLE: begin
          if (timer == '0) begin
            state    <= MEASURE;
            timer    <= TW'(GATE_CYCLES - 1);
            edge_cnt <= '0;
            ovf      <= 1'b0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        MEASURE: begin
          edge_cnt <= cnt_next;
          ovf      <= ovf_next;
          if (timer == '0) begin
            // Results taken from the next-values so an edge in the last
            // gate cycle is included in the reported count.
            state        <= DONE;
            osc_rst      <= 1'b1;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            bus.count    <= cnt_next;
            bus.overflow <= ovf_next;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
